// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit between the PC register and IF/ID.
// Issues one outstanding read at a time, buffers one response while the
// pipeline is stalled, and flushes in-flight work on a jump.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (trap PCs with pc_i[1:0] != 0
// instead of silently word-aligning them).
`timescale 1ns/1ps
module ifu_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    input  logic        stall_i,
    output logic [2:0]  hold_flag_o,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        misalign_o
);
    localparam logic [31:0] RESET_NOP = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [2:0]  HOLD_PC   = 3'b001;
    localparam logic [2:0]  HOLD_NONE = 3'b000;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] skid_inst_q, skid_addr_q;
    logic [31:0] inst_q, inst_addr_q;
    logic        inst_valid_q, misalign_q;

    logic [31:0] pc_aligned;
    logic        misaligned;
    logic        gnt_eff;
    logic        deliver_wait, deliver_hold, deliver_mis, deliver;

    assign pc_aligned = {pc_i[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
`else
    // Low PC bits are deliberately ignored; the fetch address is word-aligned.
    logic unused_pc_low;
    assign unused_pc_low = ^pc_i[1:0];
    assign misaligned    = 1'b0;
`endif

    // A grant only counts while a request is actually on the bus.
    assign gnt_eff = ibus_gnt_i & ~misaligned;

    // Deliver cycles: the only cycles in which the PC is allowed to advance.
    assign deliver_wait = (state_q == S_WAIT) & ibus_rvalid_i & ~stall_i & ~jump_flag_i;
    assign deliver_hold = (state_q == S_HOLD) & ~stall_i & ~jump_flag_i;
    assign deliver_mis  = (state_q == S_REQ) & misaligned & ~stall_i & ~jump_flag_i;
    assign deliver      = deliver_wait | deliver_hold | deliver_mis;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a jump takes priority over bus and stall events.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (jump_flag_i) begin
                    state_d = gnt_eff ? S_DROP : S_REQ;
                end else if (gnt_eff) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jump_flag_i) begin
                    state_d = ibus_rvalid_i ? S_REQ : S_DROP;
                end else if (ibus_rvalid_i) begin
                    state_d = stall_i ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (jump_flag_i || !stall_i) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // A jump here leaves the abandoned request outstanding; its
                // response still has to be swallowed before fetching again,
                // and the new target is picked up from pc_i in REQ.
                if (ibus_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Bus request and PC hold outputs; both are quiet during reset.
    always_comb begin
        ibus_req_o  = 1'b0;
        ibus_addr_o = pc_aligned;
        hold_flag_o = HOLD_PC;
        if (rst) begin
            hold_flag_o = HOLD_NONE;
        end else begin
            ibus_req_o  = (state_q == S_REQ) & ~misaligned;
            hold_flag_o = deliver ? HOLD_NONE : HOLD_PC;
        end
    end

    // Skid buffer: catches a response that arrives while IF/ID is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_inst_q <= RESET_NOP;
            skid_addr_q <= 32'h0;
        end else if ((state_q == S_WAIT) && ibus_rvalid_i && stall_i && !jump_flag_i) begin
            skid_inst_q <= ibus_rdata_i;
            skid_addr_q <= pc_aligned;
        end
    end

    // IF/ID output registers: load on deliver, flush on jump, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= RESET_NOP;
            inst_addr_q  <= 32'h0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else if (deliver) begin
            inst_valid_q <= 1'b1;
            misalign_q   <= deliver_mis;
            if (deliver_wait) begin
                inst_q      <= ibus_rdata_i;
                inst_addr_q <= pc_aligned;
            end else if (deliver_hold) begin
                inst_q      <= skid_inst_q;
                inst_addr_q <= skid_addr_q;
            end else begin
                inst_q      <= RESET_NOP;
                inst_addr_q <= pc_i;
            end
        end else if (jump_flag_i || !stall_i) begin
            inst_valid_q <= 1'b0;
            inst_q       <= RESET_NOP;
            misalign_q   <= 1'b0;
        end
    end

    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table and hand sequences for ifu_fetch,
// followed by a randomized run against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_ifu_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [2:0]  H1  = 3'b001;
    localparam logic [2:0]  H0  = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        jump, stall, gnt, rvalid;
    logic [31:0] rdata;
    logic [2:0]  hold_flag_o;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic [31:0] inst_o, inst_addr_o;
    logic        inst_valid_o, misalign_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc),
        .jump_flag_i  (jump),
        .stall_i      (stall),
        .hold_flag_o  (hold_flag_o),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (gnt),
        .ibus_rvalid_i(rvalid),
        .ibus_rdata_i (rdata),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .misalign_o   (misalign_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        jump, stall, gnt, rv;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_baddr;
        logic [2:0]  exp_hold;
        logic        exp_valid;
        logic [31:0] exp_inst, exp_iaddr;
        logic        exp_mis;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] p, input logic jmp, stl, gn, rv,
                                input logic [31:0] rd, input logic e_req,
                                input logic [31:0] e_baddr, input logic [2:0] e_hold,
                                input logic e_valid, input logic [31:0] e_inst, e_iaddr,
                                input logic e_mis = 1'b0);
        vec_t v;
        v.pc = p; v.jump = jmp; v.stall = stl; v.gnt = gn; v.rv = rv; v.rdata = rd;
        v.exp_req = e_req; v.exp_baddr = e_baddr; v.exp_hold = e_hold;
        v.exp_valid = e_valid; v.exp_inst = e_inst; v.exp_iaddr = e_iaddr; v.exp_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock of directed stimulus: combinational checks before the edge,
    // registered checks just after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        pc = v.pc; jump = v.jump; stall = v.stall;
        gnt = v.gnt; rvalid = v.rv; rdata = v.rdata;
        #1;
        chk($sformatf("%s.req", tag), {31'b0, ibus_req_o}, {31'b0, v.exp_req});
        if (v.exp_req) chk($sformatf("%s.baddr", tag), ibus_addr_o, v.exp_baddr);
        chk($sformatf("%s.hold", tag), {29'b0, hold_flag_o}, {29'b0, v.exp_hold});
        @(posedge clk); #1;
        chk($sformatf("%s.valid", tag), {31'b0, inst_valid_o}, {31'b0, v.exp_valid});
        chk($sformatf("%s.inst", tag), inst_o, v.exp_inst);
        chk($sformatf("%s.iaddr", tag), inst_addr_o, v.exp_iaddr);
        chk($sformatf("%s.mis", tag), {31'b0, misalign_o}, {31'b0, v.exp_mis});
        $display("%s: pc=%08h j=%b s=%b g=%b rv=%b -> valid=%b inst=%08h addr=%08h",
                 tag, v.pc, v.jump, v.stall, v.gnt, v.rv, inst_valid_o, inst_o, inst_addr_o);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; pc = 32'h0; jump = 1'b0; stall = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("%s.req", tag), {31'b0, ibus_req_o}, 32'h0);
            chk($sformatf("%s.hold", tag), {29'b0, hold_flag_o}, 32'h0);
            @(posedge clk); #1;
            chk($sformatf("%s.inst", tag), inst_o, NOP);
            chk($sformatf("%s.iaddr", tag), inst_addr_o, 32'h0);
            chk($sformatf("%s.valid", tag), {31'b0, inst_valid_o}, 32'h0);
            chk($sformatf("%s.mis", tag), {31'b0, misalign_o}, 32'h0);
            $display("%s: cycle %0d valid=%b inst=%08h", tag, i, inst_valid_o, inst_o);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; pc = 32'h0; jump = 1'b0; stall = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;

        // Zero-wait fetches, a 4-cycle stall into the skid buffer, then a
        // slow grant (3 cycles) and slow response (2 cycles).
        tbl.push_back(mk(32'h0, 0,0,1,0, 32'h0,        1, 32'h0, H1, 0, NOP,        32'h0));
        tbl.push_back(mk(32'h0, 0,0,0,1, KEY,          0, 32'h0, H0, 1, KEY,        32'h0));
        tbl.push_back(mk(32'h4, 0,0,1,0, 32'h0,        1, 32'h4, H1, 0, NOP,        32'h0));
        tbl.push_back(mk(32'h4, 0,0,0,1, KEY | 32'h4,  0, 32'h0, H0, 1, KEY | 32'h4, 32'h4));
        tbl.push_back(mk(32'h8, 0,0,1,0, 32'h0,        1, 32'h8, H1, 0, NOP,        32'h4));
        tbl.push_back(mk(32'h8, 0,1,0,1, KEY | 32'h8,  0, 32'h0, H1, 0, NOP,        32'h4));
        tbl.push_back(mk(32'h8, 0,1,0,0, 32'h0,        0, 32'h0, H1, 0, NOP,        32'h4));
        tbl.push_back(mk(32'h8, 0,1,0,0, 32'h0,        0, 32'h0, H1, 0, NOP,        32'h4));
        tbl.push_back(mk(32'h8, 0,1,0,0, 32'h0,        0, 32'h0, H1, 0, NOP,        32'h4));
        tbl.push_back(mk(32'h8, 0,0,0,0, 32'h0,        0, 32'h0, H0, 1, KEY | 32'h8, 32'h8));
        tbl.push_back(mk(32'hC, 0,0,0,0, 32'h0,        1, 32'hC, H1, 0, NOP,        32'h8));
        tbl.push_back(mk(32'hC, 0,1,0,0, 32'h0,        1, 32'hC, H1, 0, NOP,        32'h8));
        tbl.push_back(mk(32'hC, 0,0,0,0, 32'h0,        1, 32'hC, H1, 0, NOP,        32'h8));
        tbl.push_back(mk(32'hC, 0,0,1,0, 32'h0,        1, 32'hC, H1, 0, NOP,        32'h8));
        tbl.push_back(mk(32'hC, 0,0,0,0, 32'h0,        0, 32'h0, H1, 0, NOP,        32'h8));
        tbl.push_back(mk(32'hC, 0,0,0,0, 32'h0,        0, 32'h0, H1, 0, NOP,        32'h8));
        tbl.push_back(mk(32'hC, 0,0,0,1, KEY | 32'hC,  0, 32'h0, H0, 1, KEY | 32'hC, 32'hC));

        do_reset("reset");
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Jump while waiting for data: stale response must be swallowed.
        apply(mk(32'h10,  0,0,1,0, 32'h0,          1, 32'h10,  H1, 0, NOP, 32'hC), "jw.req");
        apply(mk(32'h100, 1,0,0,0, 32'h0,          0, 32'h0,   H1, 0, NOP, 32'hC), "jw.jump");
        apply(mk(32'h100, 0,0,0,0, 32'h0,          0, 32'h0,   H1, 0, NOP, 32'hC), "jw.drop");
        apply(mk(32'h100, 0,0,0,1, 32'hDEAD_BEEF,  0, 32'h0,   H1, 0, NOP, 32'hC), "jw.stale");
        apply(mk(32'h100, 0,0,1,0, 32'h0,          1, 32'h100, H1, 0, NOP, 32'hC), "jw.newreq");
        apply(mk(32'h100, 0,0,0,1, KEY | 32'h100,  0, 32'h0,   H0, 1, KEY | 32'h100, 32'h100), "jw.deliver");

        // Jump while holding buffered data under stall.
        apply(mk(32'h104, 0,1,1,0, 32'h0,          1, 32'h104, H1, 1, KEY | 32'h100, 32'h100), "jh.req");
        apply(mk(32'h104, 0,1,0,1, 32'h1234_5678,  0, 32'h0,   H1, 1, KEY | 32'h100, 32'h100), "jh.skid");
        apply(mk(32'h104, 0,1,0,0, 32'h0,          0, 32'h0,   H1, 1, KEY | 32'h100, 32'h100), "jh.hold");
        apply(mk(32'h200, 1,1,0,0, 32'h0,          0, 32'h0,   H1, 0, NOP, 32'h100), "jh.jump");
        apply(mk(32'h200, 0,0,0,0, 32'h0,          1, 32'h200, H1, 0, NOP, 32'h100), "jh.req2");
        apply(mk(32'h200, 0,0,1,0, 32'h0,          1, 32'h200, H1, 0, NOP, 32'h100), "jh.gnt");
        apply(mk(32'h200, 0,0,0,1, KEY | 32'h200,  0, 32'h0,   H0, 1, KEY | 32'h200, 32'h200), "jh.deliver");

        // Jump in REQ coinciding with a grant.
        apply(mk(32'h300, 1,0,1,0, 32'h0,          1, 32'h300, H1, 0, NOP, 32'h200), "jr.jump");
        apply(mk(32'h300, 0,0,0,0, 32'h0,          0, 32'h0,   H1, 0, NOP, 32'h200), "jr.drop");
        apply(mk(32'h300, 0,0,0,1, 32'hBAD0_BAD0,  0, 32'h0,   H1, 0, NOP, 32'h200), "jr.stale");
        apply(mk(32'h300, 0,0,1,0, 32'h0,          1, 32'h300, H1, 0, NOP, 32'h200), "jr.req");
        apply(mk(32'h300, 0,0,0,1, KEY | 32'h300,  0, 32'h0,   H0, 1, KEY | 32'h300, 32'h300), "jr.deliver");

`ifdef IFU_MISALIGN_CHECK_EN
        apply(mk(32'h102, 0,0,0,0, 32'h0,          0, 32'h0,   H0, 1, NOP, 32'h102, 1'b1), "mis.trap");
        apply(mk(32'h108, 0,0,0,0, 32'h0,          1, 32'h108, H1, 0, NOP, 32'h102, 1'b0), "mis.next");
`else
        apply(mk(32'h102, 0,0,1,0, 32'h0,          1, 32'h100, H1, 0, NOP, 32'h300), "ua.req");
        apply(mk(32'h102, 0,0,0,1, KEY | 32'h100,  0, 32'h0,   H0, 1, KEY | 32'h100, 32'h100), "ua.deliver");
`endif

        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Randomized run: the bench acts as PC register and as a memory with
    // random grant/response latency. The model tracks, per transaction,
    // whether a live (post-jump) instruction is available and at what address.
    task automatic run_random();
        int          gnt_cnt, rv_cnt, ndel;
        bit          pend, pend_live, have_data, avail, deliver_exp;
        logic [31:0] pend_addr, data_addr, a_addr, pc_m;
        logic [31:0] addr_s;
        logic [2:0]  hold_s;
        logic        req_s;
        logic        prev_valid;
        logic [31:0] prev_inst, prev_iaddr;

        do_reset("rreset");
        pend = 0; pend_live = 0; have_data = 0; data_addr = 0; pend_addr = 0;
        rv_cnt = 0; gnt_cnt = $urandom_range(0, 3); pc_m = 32'h0; ndel = 0;
        prev_valid = 1'b0; prev_inst = NOP; prev_iaddr = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            jump  = ($urandom_range(0, 99) < 3);
            stall = ($urandom_range(0, 99) < 30);
            if (jump) pc_m = $urandom_range(0, 1023) << 2;
            pc = pc_m;
            #1;
            gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
            if (pend && rv_cnt == 0) begin
                rvalid = 1'b1;
                rdata  = pend_addr ^ KEY;
            end
            if (ibus_req_o && gnt_cnt == 0) gnt = 1'b1;
            #1;
            hold_s = hold_flag_o; req_s = ibus_req_o; addr_s = ibus_addr_o;

            avail  = have_data;
            a_addr = data_addr;
            if (rvalid && pend_live) begin
                avail  = 1'b1;
                a_addr = pend_addr;
            end
            deliver_exp = avail && !stall && !jump;

            chk("rnd.hold", {29'b0, hold_s}, deliver_exp ? 32'h0 : 32'h1);
            chk("rnd.single", {31'b0, req_s & pend}, 32'h0);
            if (req_s) chk("rnd.baddr", addr_s, pc_m);

            @(posedge clk);
            if (rvalid) pend = 0;
            else if (pend && rv_cnt > 0) rv_cnt--;
            if (jump) pend_live = 0;
            if (gnt) begin
                pend      = 1;
                pend_live = !jump;
                pend_addr = addr_s;
                rv_cnt    = $urandom_range(0, 2);
                gnt_cnt   = $urandom_range(0, 3);
            end else if (req_s && gnt_cnt > 0) begin
                gnt_cnt--;
            end
            if (jump) begin
                have_data = 0;
            end else begin
                have_data = avail && !deliver_exp;
                data_addr = a_addr;
            end
            if (!jump && hold_s == 3'b000) pc_m = pc_m + 32'd4;
            #1;

            if (jump) begin
                chk("rnd.jvalid", {31'b0, inst_valid_o}, 32'h0);
                chk("rnd.jinst", inst_o, NOP);
                prev_valid = 1'b0; prev_inst = NOP;
            end else if (deliver_exp) begin
                chk("rnd.valid", {31'b0, inst_valid_o}, 32'h1);
                chk("rnd.iaddr", inst_addr_o, a_addr);
                chk("rnd.inst", inst_o, a_addr ^ KEY);
                prev_valid = 1'b1; prev_inst = a_addr ^ KEY; prev_iaddr = a_addr;
                ndel++;
                $display("rnd deliver %0d: addr=%08h inst=%08h", ndel, inst_addr_o, inst_o);
            end else if (stall) begin
                chk("rnd.svalid", {31'b0, inst_valid_o}, {31'b0, prev_valid});
                chk("rnd.sinst", inst_o, prev_inst);
                chk("rnd.siaddr", inst_addr_o, prev_iaddr);
            end else begin
                chk("rnd.idle", {31'b0, inst_valid_o}, 32'h0);
                chk("rnd.inop", inst_o, NOP);
                prev_valid = 1'b0; prev_inst = NOP;
            end
        end
        chk("rnd.progress", {31'b0, (ndel >= 100)}, 32'h1);
        jump = 1'b0; stall = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    endtask

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit that sits on the far side of the PC register: it takes the current `pc_i`, issues a single-outstanding read on the instruction bus, and returns the fetched instruction with its address to the IF/ID stage. It drives `hold_flag_o` back to the PC register so the PC advances only on the cycle an instruction is handed downstream. It honours `jump_flag_i` by flushing any in-flight or buffered fetch, and honours downstream stalls through a one-entry skid buffer.

## Interface
- `RESET_NOP`, 32'h0000_0013, value driven on `inst_o` when no valid instruction is presented (`addi x0,x0,0`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pc_i` input 32: fetch address from the PC register.
- `jump_flag_i` input 1: redirect/flush; `pc_i` already carries the target, or will carry it next cycle.
- `stall_i` input 1: downstream cannot accept an instruction this cycle.
- `hold_flag_o` output 3: 3'b001 (HOLD_PC) = PC must hold; 3'b000 = PC may advance.
- `ibus_req_o` output 1: read request.
- `ibus_addr_o` output 32: read address.
- `ibus_gnt_i` input 1: request accepted this cycle.
- `ibus_rvalid_i` input 1: read data valid; it comes at least one cycle after the `gnt` of the same request.
- `ibus_rdata_i` input 32: read data.
- `inst_o` output 32: instruction to IF/ID (registered).
- `inst_addr_o` output 32: address of `inst_o` (registered).
- `inst_valid_o` output 1: `inst_o` is valid (registered).
- `misalign_o` output 1: fetch-address-misaligned flag (registered; see Configuration).

## Operation
- FSM states: REQ, WAIT, HOLD, DROP. Reset state: REQ.
- REQ
  - `ibus_req_o`=1, `ibus_addr_o`={`pc_i`[31:2],2'b00}.
  - `gnt` → WAIT. No `gnt` → stay.
  - `req` is withdrawn without `gnt` on a jump; this is legal on the bus.
- WAIT
  - `ibus_req_o`=0.
  - `rvalid` & !`stall_i` → capture into the output regs, → REQ.
  - `rvalid` & `stall_i` → capture `rdata`/`pc_i` into the skid buffer, → HOLD.
- HOLD
  - Wait until !`stall_i`, then move the buffer to the output regs, → REQ.
- DROP
  - Wait for the `rvalid` of the abandoned request and discard its data, → REQ.
  - No new request is issued while in DROP.
- Jump has priority over every other event. `jump_flag_i`=1:
  - In REQ with `gnt` that cycle → DROP. In REQ without `gnt` → REQ.
  - In WAIT: with `rvalid` that cycle → REQ, data discarded. Without `rvalid` → DROP.
  - In HOLD → REQ, buffer discarded. In DROP → DROP.
- `hold_flag_o` = 3'b000 only in the "deliver" cycle (WAIT & `rvalid` & !`stall_i` & !jump, or HOLD & !`stall_i` & !jump). Otherwise it is 3'b001.
- Output registers:
  - On deliver: `inst_o`/`inst_addr_o` are loaded and `inst_valid_o`<=1.
  - Else if `stall_i`: all three hold their value.
  - Else: `inst_valid_o`<=0 and `inst_o`<=`RESET_NOP`. `inst_addr_o` holds.
  - `jump_flag_i` clears `inst_valid_o` and loads `RESET_NOP`, regardless of `stall_i`.
- The fetched address is the `pc_i` value at the deliver cycle. `pc_i` is stable from REQ through deliver because hold is asserted.

## Timing
- Reset values (while `rst`=1 and the cycle after):
  - `inst_o`=`RESET_NOP`, `inst_addr_o`=0, `inst_valid_o`=0, `misalign_o`=0.
  - Combinational `ibus_req_o`=0 and `hold_flag_o`=3'b000 during `rst`.
- Best-case throughput: one instruction per 2 cycles (REQ with same-cycle `gnt`, then `rvalid` in the next cycle).
- Latency: `inst_valid_o` rises on the clock edge that ends the deliver cycle. The PC increments on the same edge.
- Reset mid-transaction: the FSM returns to REQ and outstanding responses are not tracked. The bus must be reset together with this block.

## Configuration
- Macro `IFU_MISALIGN_CHECK_EN`.
- Defined:
  - In REQ, if `pc_i`[1:0]≠0, no bus request is issued.
  - That cycle is a deliver cycle: `inst_o`=`RESET_NOP`, `inst_addr_o`=`pc_i`, `inst_valid_o`=1, `misalign_o`=1 for one cycle. Stall and jump rules apply as for a normal deliver.
- Undefined:
  - `misalign_o` is tied to 0.
  - `pc_i`[1:0] is ignored; the address is forced word-aligned.

## Test plan
- Zero-wait bus:
  - Stimulus: `gnt` same cycle, `rvalid` next cycle, PC from 0x0 with rdata=addr^0xA5A5_0000.
  - Response: `inst_valid_o` every other cycle with `inst_addr_o` 0x0, 0x4, 0x8.
- 3-cycle `gnt` delay plus 2-cycle `rvalid` delay:
  - Response: `hold_flag_o`=3'b001 throughout; exactly one deliver; `ibus_addr_o` stable while `req`=1.
- Jump while in WAIT:
  - Stimulus: jump to 0x100 before `rvalid`.
  - Response: DROP entered; the stale `rvalid` produces no `inst_valid_o`; the next request has address 0x100.
- `rvalid` while `stall_i`=1 for 4 cycles:
  - Response: data held in HOLD; delivered the cycle after `stall_i` falls; PC held until then.
- Jump in HOLD together with `stall_i`=1:
  - Response: buffer discarded; `inst_valid_o`=0 and `inst_o`=0x0000_0013 next cycle.
- With `IFU_MISALIGN_CHECK_EN`, `pc_i`=0x102:
  - Response: no `ibus_req_o`; `misalign_o`=1 and `inst_addr_o`=0x102 for one cycle.
